// File: rtl/vec_elem_seq_pkg.sv
// Shared types for the vector element sequencer: op encoding,
// sequencer state encoding and default geometry.
package vecunit_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 10;
    localparam int VL_W_DEF  = 8;

    typedef enum logic [2:0] {
        VOP_ADD  = 3'd0,
        VOP_SUB  = 3'd1,
        VOP_MUL  = 3'd2,
        VOP_AND  = 3'd3,
        VOP_OR   = 3'd4,
        VOP_XOR  = 3'd5,
        VOP_MAXU = 3'd6,
        VOP_MINU = 3'd7
    } vop_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/vec_elem_seq_if.sv
// Command, status and dual-read/single-write memory bundle.
// slave: sequencer side; master: controller + memory side.
interface vec_elem_seq_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10,
    parameter int VL_W  = 8
) ();
    logic             start;
    logic [2:0]       op;
    logic [DEPTH-1:0] base_a;
    logic [DEPTH-1:0] base_b;
    logic [DEPTH-1:0] base_d;
    logic [VL_W-1:0]  vl;
    logic             ready;
    logic             done;
    logic [DEPTH-1:0] addr_A_read;
    logic [DEPTH-1:0] addr_B_read;
    logic [WIDTH-1:0] rd_A_i;
    logic [WIDTH-1:0] rd_B_i;
    logic [DEPTH-1:0] addr_write;
    logic [WIDTH-1:0] data;
    logic             w_en;

    modport slave (
        input  start, op, base_a, base_b, base_d, vl,
        input  rd_A_i, rd_B_i,
        output ready, done, addr_A_read, addr_B_read,
        output addr_write, data, w_en
    );

    modport master (
        output start, op, base_a, base_b, base_d, vl,
        output rd_A_i, rd_B_i,
        input  ready, done, addr_A_read, addr_B_read,
        input  addr_write, data, w_en
    );
endinterface

// File: rtl/vec_elem_seq_alu.sv
// vec_alu: combinational element ALU, modulo 2**WIDTH.
// Ports: op (vop_e), a, b -> y.
module vec_alu
    import vecunit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  vop_e             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            VOP_ADD:  y = a + b;
            VOP_SUB:  y = a - b;
            VOP_MUL:  y = a * b;
            VOP_AND:  y = a & b;
            VOP_OR:   y = a | b;
            VOP_XOR:  y = a ^ b;
            VOP_MAXU: y = (a > b) ? a : b;
            VOP_MINU: y = (a < b) ? a : b;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/vec_elem_seq.sv
// vec_elem_seq: walks vl element pairs, one ALU op and one write per cycle.
// Ports: clk, rst (async high), bus (vec_elem_seq_if.slave).
module vec_elem_seq
    import vecunit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int VL_W  = VL_W_DEF
) (
    input logic          clk,
    input logic          rst,
    vec_elem_seq_if.slave bus
);
    seq_state_e       state;
    vop_e             op_r;
    logic [DEPTH-1:0] ba_r;
    logic [DEPTH-1:0] bb_r;
    logic [DEPTH-1:0] bd_r;
    logic [VL_W-1:0]  vl_r;
    logic [VL_W-1:0]  idx;
    logic [DEPTH-1:0] idx_a;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] data_r;
    logic [DEPTH-1:0] waddr_r;
    logic             w_en_r;
    logic             done_r;

    // idx holds on the last element, so read addresses keep their
    // final value while idle.
    assign idx_a           = DEPTH'(idx);
    assign bus.addr_A_read = ba_r + idx_a;
    assign bus.addr_B_read = bb_r + idx_a;
    assign bus.ready       = (state == S_IDLE);
    assign bus.data        = data_r;
    assign bus.addr_write  = waddr_r;
    assign bus.w_en        = w_en_r;
    assign bus.done        = done_r;

    vec_alu #(.WIDTH(WIDTH)) u_alu (
        .op (op_r),
        .a  (bus.rd_A_i),
        .b  (bus.rd_B_i),
        .y  (alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op_r    <= VOP_ADD;
            ba_r    <= '0;
            bb_r    <= '0;
            bd_r    <= '0;
            vl_r    <= '0;
            idx     <= '0;
            data_r  <= '0;
            waddr_r <= '0;
            w_en_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            w_en_r <= 1'b0;
            done_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_r <= vop_e'(bus.op);
                        ba_r <= bus.base_a;
                        bb_r <= bus.base_b;
                        bd_r <= bus.base_d;
                        vl_r <= bus.vl;
                        idx  <= '0;
                        if (bus.vl == '0) begin
                            state  <= S_DRAIN;
                            done_r <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    data_r  <= alu_y;
                    waddr_r <= bd_r + idx_a;
                    w_en_r  <= 1'b1;
                    if (idx == vl_r - 1'b1) begin
                        state  <= S_DRAIN;
                        done_r <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DRAIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
